// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial adder: one four_bit_CLA_adder pass per clock, with the carry registered between nibbles.
// Optional macro CLA_SERIAL_OVF_EN adds the out_ovf signed-overflow output.

module four_bit_CLA_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] sum,
    output logic       c4
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is formed directly from generate/propagate terms, without rippling.
    assign w_c[0] = c0;
    assign w_c[1] = w_g[0] | (w_p[0] & c0);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c0);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c0);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c0);

    assign sum = w_p ^ w_c[3:0];
    assign c4  = w_c[4];
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef CLA_SERIAL_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;
`ifdef CLA_SERIAL_OVF_EN
    logic             r_out_ovf;
`endif

    logic [IDXW+1:0]  w_base;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum;
    logic             w_c4;
    logic [WIDTH-1:0] w_result_next;

    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];

    four_bit_CLA_adder u_cla (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .c0  (r_carry),
        .sum (w_sum),
        .c4  (w_c4)
    );

    // Result with the current nibble merged in, so the final edge can publish it directly.
    always_comb begin
        w_result_next = r_result;
        w_result_next[w_base +: 4] = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            r_out_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_result   <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_c4;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                        r_out_sum   <= w_result_next;
                        r_out_cout  <= w_c4;
                        r_out_valid <= 1'b1;
`ifdef CLA_SERIAL_OVF_EN
                        r_out_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[3] ^ w_c4;
`endif
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign busy      = r_busy;
`ifdef CLA_SERIAL_OVF_EN
    assign out_ovf   = r_out_ovf;
`endif
endmodule
